wide_add_sequencer: RTL and testbench

Multi-cycle controller that performs 32·WORDS-bit two's-complement addition by sequencing a single 32-bit `CarrySelect` adder over the operand words, LSW first. The carry is chained through a register between words. Start/done handshake plus signed-overflow and carry-out flags are provided. It sits between the datapath's wide operand registers and the shared 32-bit adder, so no wide combinational adder is needed.

---
 rtl/wide_add_sequencer.sv | 135 +++++++++++++
 tb/tb_wide_add_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/wide_add_sequencer.sv
// Word-serial wide adder: sequences one 32-bit CarrySelect adder across WORDS words, LSW first.
// Define WIDE_ADD_SUB_EN to add the op input (1 = subtract, a - b).

module CarrySelect (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cin,
    output logic [31:0] Sum,
    output logic        Cout
);
    logic [16:0] lo;
    logic [16:0] hi0;
    logic [16:0] hi1;

    // Both upper-half results are precomputed; the lower-half carry picks one.
    assign lo  = {1'b0, A[15:0]} + {1'b0, B[15:0]} + {16'b0, Cin};
    assign hi0 = {1'b0, A[31:16]} + {1'b0, B[31:16]};
    assign hi1 = {1'b0, A[31:16]} + {1'b0, B[31:16]} + 17'd1;

    assign Sum  = {(lo[16] ? hi1[15:0] : hi0[15:0]), lo[15:0]};
    assign Cout = lo[16] ? hi1[16] : hi0[16];
endmodule

module wide_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [32*WORDS-1:0] a,
    input  logic [32*WORDS-1:0] b,
    input  logic                cin,
`ifdef WIDE_ADD_SUB_EN
    input  logic                op,
`endif
    output logic                busy,
    output logic                done,
    output logic [32*WORDS-1:0] sum,
    output logic                cout,
    output logic                ovf
);
    localparam int IW = $clog2(WORDS);
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state;
    state_t next_state;

    logic [WORDS-1:0][31:0] a_q;
    logic [WORDS-1:0][31:0] b_q;
    logic [WORDS-1:0][31:0] sum_q;
    logic [IW-1:0]          idx;
    logic                   carry;

    logic                   accept;
    logic                   last_word;
    logic [32*WORDS-1:0]    b_eff;
    logic                   carry_init;
    logic [31:0]            add_sum;
    logic                   add_cout;

    assign accept    = start && (state != RUN);
    assign last_word = (idx == LAST);

`ifdef WIDE_ADD_SUB_EN
    // Subtraction is a + ~b + 1; cin is ignored when op is set.
    assign b_eff      = op ? ~b : b;
    assign carry_init = op ? 1'b1 : cin;
`else
    assign b_eff      = b;
    assign carry_init = cin;
`endif

    CarrySelect u_adder (
        .A    (a_q[idx]),
        .B    (b_q[idx]),
        .Cin  (carry),
        .Sum  (add_sum),
        .Cout (add_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last_word) next_state = DONE;
            DONE:    next_state = start ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Operand capture, word-serial accumulation and final flag capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
            idx   <= '0;
            carry <= 1'b0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b_eff;
            idx   <= '0;
            carry <= carry_init;
        end else if (state == RUN) begin
            sum_q[idx] <= add_sum;
            carry      <= add_cout;
            if (last_word) begin
                cout <= add_cout;
                ovf  <= (a_q[WORDS-1][31] == b_q[WORDS-1][31]) &&
                        (add_sum[31] != a_q[WORDS-1][31]);
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign sum = sum_q;
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Scoreboard bench for wide_add_sequencer at WORDS=4: directed vectors with hand-computed results.
// Define WIDE_ADD_SUB_EN to also exercise subtraction.

module tb_wide_add_sequencer;
    localparam int WORDS = 4;
    localparam int W     = 32 * WORDS;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef WIDE_ADD_SUB_EN
    logic         op;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    wide_add_sequencer #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef WIDE_ADD_SUB_EN
        .op    (op),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge; presents one request across the next rising edge.
    task automatic applyStimulus(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vcin,
                                 input logic vop, input bit push, input logic [W-1:0] esum,
                                 input logic ecout, input logic eovf, input string nm);
        exp_t e;
        a     = va;
        b     = vb;
        cin   = vcin;
`ifdef WIDE_ADD_SUB_EN
        op    = vop;
`endif
        start = 1'b1;
        if (push) begin
            e.sum  = esum;
            e.cout = ecout;
            e.ovf  = eovf;
            e.name = nm;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts negedges until done; returns at the negedge where done is seen.
    task automatic waitDone(input int expLat, input string nm);
        int  cycles = 0;
        bit  seen   = 0;
        while (!seen && cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (done) begin
                seen = 1;
                checkOutput({nm, "_busy_in_done"}, W'(busy), W'(0));
            end else begin
                checkOutput({nm, "_busy_in_run"}, W'(busy), W'(1));
                @(posedge clk);
            end
        end
        if (!seen) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s_timeout: no done within %0d cycles, expected %0d", nm, cycles, expLat);
        end else begin
            checkOutput({nm, "_latency"}, W'(cycles), W'(expLat));
        end
    endtask

    // Monitor: every done pulse is matched against the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_done: got done with sum %h, expected no done", sum);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput({e.name, "_sum"}, sum, e.sum);
                checkOutput({e.name, "_cout"}, W'(cout), W'(e.cout));
                checkOutput({e.name, "_ovf"}, W'(ovf), W'(e.ovf));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
`ifdef WIDE_ADD_SUB_EN
        op    = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", W'(busy), W'(0));
        checkOutput("reset_done", W'(done), W'(0));
        checkOutput("reset_sum", sum, W'(0));
        checkOutput("reset_cout", W'(cout), W'(0));
        checkOutput("reset_ovf", W'(ovf), W'(0));
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus({1'b0, {(W-1){1'b1}}}, W'(1), 1'b0, 1'b0, 1,
                      {1'b1, {(W-1){1'b0}}}, 1'b0, 1'b1, "max_pos_plus1");
        waitDone(5, "max_pos_plus1");
        @(negedge clk);

        applyStimulus({W{1'b1}}, W'(1), 1'b0, 1'b0, 1, W'(0), 1'b1, 1'b0, "ripple_all");
        waitDone(5, "ripple_all");
        @(negedge clk);

        applyStimulus(W'(100), -W'(200), 1'b0, 1'b0, 1, -W'(100), 1'b0, 1'b0, "pos_plus_neg");
        waitDone(5, "pos_plus_neg");
        @(negedge clk);

        applyStimulus(-W'(50), -W'(100), 1'b1, 1'b0, 1, -W'(149), 1'b1, 1'b0, "neg_plus_neg_cin");
        waitDone(5, "neg_plus_neg_cin");
        @(negedge clk);

        // Start pulse at idx 1 must not disturb the running operation.
        applyStimulus(W'(3), W'(4), 1'b0, 1'b0, 1, W'(7), 1'b0, 1'b0, "ignore_start");
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(W'(9), W'(9), 1'b0, 1'b0, 0, '0, 1'b0, 1'b0, "");
        waitDone(3, "ignore_start");
        applyStimulus(W'(64'h1_0000_0000), W'(32'hFFFF_FFFF), 1'b1, 1'b0, 1,
                      W'(64'h2_0000_0000), 1'b0, 1'b0, "back_to_back");
        waitDone(5, "back_to_back");
        @(negedge clk);
        checkOutput("b2b_sum_holds", sum, W'(64'h2_0000_0000));

        // Reset at idx 2 aborts; no done may follow.
        applyStimulus(W'(1), W'(2), 1'b0, 1'b0, 0, '0, 1'b0, 1'b0, "");
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", W'(busy), W'(0));
        checkOutput("abort_done", W'(done), W'(0));
        checkOutput("abort_sum", sum, W'(0));
        checkOutput("abort_cout", W'(cout), W'(0));
        checkOutput("abort_ovf", W'(ovf), W'(0));
        repeat (8) @(negedge clk);
        checkOutput("abort_idle", W'(busy | done), W'(0));

        applyStimulus(W'(5), W'(7), 1'b0, 1'b0, 1, W'(12), 1'b0, 1'b0, "after_abort");
        waitDone(5, "after_abort");
        @(negedge clk);

`ifdef WIDE_ADD_SUB_EN
        applyStimulus(W'(50), W'(100), 1'b0, 1'b1, 1, -W'(50), 1'b0, 1'b0, "sub_small");
        waitDone(5, "sub_small");
        @(negedge clk);

        applyStimulus({1'b1, {(W-1){1'b0}}}, W'(1), 1'b0, 1'b1, 1,
                      {1'b0, {(W-1){1'b1}}}, 1'b1, 1'b1, "sub_min_minus1");
        waitDone(5, "sub_min_minus1");
        @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", W'(sb.size()), W'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
